// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory-unit FSM states, MDR source selects, word width.
package lc3_pkg;

  localparam int LC3_WORD_W = 16;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'b00,
    MEM_RD_WAIT = 2'b01,
    MEM_WR_WAIT = 2'b10,
    MEM_DONE    = 2'b11
  } mem_state_t;

  localparam logic [1:0] SEL_MDR_BUS = 2'b00;
  localparam logic [1:0] SEL_MDR_MEM = 2'b01;
  localparam logic [1:0] SEL_MDR_SPC = 2'b11;

endpackage

// File: rtl/lc3_sram.sv
// Single-port word RAM: write commits on the clock edge, read data is registered by the caller (MDR).
module lc3_sram
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = LC3_WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lc3_mem_unit.sv
// LC-3 memory responder: MAR/MDR, RAM and the R (mem_ready) handshake for the control FSM.
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic [15:0] mar_spc_in,
  input  logic [15:0] mdr_spc_in,
  input  logic        ld_mar,
  input  logic        ld_mar_spc,
  input  logic        ld_mdr,
  input  logic [1:0]  sel_mdr,
  input  logic        mem_we,
  input  logic        ena_mdr,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        mem_ready,
  output logic [15:0] mar_q,
  output logic [15:0] mdr_q
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  mem_state_t  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_wr, op_wr_nxt;
  logic [15:0] mar, mar_nxt;
  logic [15:0] mdr, mdr_nxt;
  logic        ready;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        rd_req;
  logic        wr_req;

  assign rd_req = ld_mdr && (sel_mdr == SEL_MDR_MEM);
  assign wr_req = mem_we;

  lc3_sram #(
    .ADDR_W (ADDR_W),
    .DATA_W (LC3_WORD_W)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mar[ADDR_W-1:0]),
    .wdata (mdr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_wr_nxt = op_wr;
    mar_nxt   = mar;
    mdr_nxt   = mdr;
    ram_we    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (ld_mar) begin
          mar_nxt = ld_mar_spc ? mar_spc_in : bus_in;
        end
        // Direct loads land on the accept edge, so a same-cycle access uses them.
        if (ld_mdr && (sel_mdr == SEL_MDR_BUS)) begin
          mdr_nxt = bus_in;
        end else if (ld_mdr && (sel_mdr == SEL_MDR_SPC)) begin
          mdr_nxt = mdr_spc_in;
        end
        if (wr_req) begin
          state_nxt = MEM_WR_WAIT;
          cnt_nxt   = LAT_INIT;
          op_wr_nxt = 1'b1;
        end else if (rd_req) begin
          state_nxt = MEM_RD_WAIT;
          cnt_nxt   = LAT_INIT;
          op_wr_nxt = 1'b0;
        end
      end
      MEM_RD_WAIT: begin
        if (cnt == 4'd0) begin
          mdr_nxt   = ram_rdata;
          state_nxt = MEM_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      MEM_WR_WAIT: begin
        if (cnt == 4'd0) begin
          ram_we    = !reset;
          state_nxt = MEM_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      MEM_DONE: begin
        // Hold R until the level-held request drops so it cannot re-issue.
        if (op_wr ? !wr_req : !rd_req) begin
          state_nxt = MEM_IDLE;
        end
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEM_IDLE;
      cnt   <= 4'd0;
      op_wr <= 1'b0;
      mar   <= 16'h0000;
      mdr   <= 16'h0000;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_wr <= op_wr_nxt;
      mar   <= mar_nxt;
      mdr   <= mdr_nxt;
      ready <= (state_nxt == MEM_DONE);
    end
  end

  assign bus_out   = ena_mdr ? mdr : 16'h0000;
  assign bus_drive = ena_mdr;
  assign mem_ready = ready;
  assign mar_q     = mar;
  assign mdr_q     = mdr;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Scoreboard bench for lc3_mem_unit: one instance at MEM_LAT=2, one at MEM_LAT=4.
module tb_lc3_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in, mar_spc_in, mdr_spc_in;
  logic        ld_mar, ld_mar_spc, ld_mdr, mem_we, ena_mdr;
  logic [1:0]  sel_mdr;
  logic        dsel;

  logic [15:0] bus_out0, mar_q0, mdr_q0, bus_out1, mar_q1, mdr_q1;
  logic        drv0, rdy0, drv1, rdy1;

  logic [15:0] bus_out_s, mar_s, mdr_s;
  logic        drv_s, rdy_s;

  logic [15:0] sb [$];
  logic [15:0] model0 [int];
  logic [15:0] model1 [int];
  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lc3_mem_unit #(.ADDR_W(8), .MEM_LAT(2)) u_dut0 (
    .clk(clk), .reset(reset), .bus_in(bus_in), .mar_spc_in(mar_spc_in),
    .mdr_spc_in(mdr_spc_in), .ld_mar(ld_mar & ~dsel), .ld_mar_spc(ld_mar_spc),
    .ld_mdr(ld_mdr & ~dsel), .sel_mdr(sel_mdr), .mem_we(mem_we & ~dsel),
    .ena_mdr(ena_mdr), .bus_out(bus_out0), .bus_drive(drv0), .mem_ready(rdy0),
    .mar_q(mar_q0), .mdr_q(mdr_q0)
  );

  lc3_mem_unit #(.ADDR_W(8), .MEM_LAT(4)) u_dut1 (
    .clk(clk), .reset(reset), .bus_in(bus_in), .mar_spc_in(mar_spc_in),
    .mdr_spc_in(mdr_spc_in), .ld_mar(ld_mar & dsel), .ld_mar_spc(ld_mar_spc),
    .ld_mdr(ld_mdr & dsel), .sel_mdr(sel_mdr), .mem_we(mem_we & dsel),
    .ena_mdr(ena_mdr), .bus_out(bus_out1), .bus_drive(drv1), .mem_ready(rdy1),
    .mar_q(mar_q1), .mdr_q(mdr_q1)
  );

  assign bus_out_s = dsel ? bus_out1 : bus_out0;
  assign mar_s     = dsel ? mar_q1 : mar_q0;
  assign mdr_s     = dsel ? mdr_q1 : mdr_q0;
  assign drv_s     = dsel ? drv1 : drv0;
  assign rdy_s     = dsel ? rdy1 : rdy0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    ld_mar = 1'b0; ld_mar_spc = 1'b0; ld_mdr = 1'b0;
    sel_mdr = 2'b00; mem_we = 1'b0; ena_mdr = 1'b0;
  endtask

  task automatic model_wr(input logic [15:0] addr, input logic [15:0] data);
    if (dsel) model1[int'(addr[7:0])] = data;
    else      model0[int'(addr[7:0])] = data;
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] addr);
    if (dsel) return model1.exists(int'(addr[7:0])) ? model1[int'(addr[7:0])] : 16'hxxxx;
    return model0.exists(int'(addr[7:0])) ? model0[int'(addr[7:0])] : 16'hxxxx;
  endfunction

  // Controls for the accept cycle must already be driven; the request stays held until DONE.
  task automatic run_access(input bit is_rd, input int exp_lat, input bit lock, input string tag);
    int lat;
    logic [15:0] exp_d;
    lat = 0;
    step();
    ld_mar = 1'b0;
    if (!is_rd) ld_mdr = 1'b0;
    if (lock) begin
      ld_mar = 1'b1; ld_mar_spc = 1'b0; bus_in = 16'h3004; mem_we = 1'b1;
      step();
      lat++;
      ld_mar = 1'b0; mem_we = 1'b0;
    end
    while (rdy_s == 1'b0 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (is_rd) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        exp_d = sb.pop_front();
        chk({tag, "_data"}, {16'h0, mdr_s}, {16'h0, exp_d});
      end
    end
    step();
    chk({tag, "_hold"}, rdy_s, 1);
    mem_we = 1'b0; ld_mdr = 1'b0;
    step();
    chk({tag, "_drop"}, rdy_s, 0);
  endtask

  task automatic read_at(input logic [15:0] addr, input int exp_lat, input bit lock, input string tag);
    // Park a different value in MDR so the read visibly replaces it.
    ld_mar = 1'b1; ld_mar_spc = 1'b0; bus_in = addr; ld_mdr = 1'b1; sel_mdr = 2'b00;
    step();
    ld_mar = 1'b0; sel_mdr = 2'b01;
    sb.push_back(model_rd(addr));
    run_access(1'b1, exp_lat, lock, tag);
  endtask

  task automatic write_spc(input logic [15:0] addr, input logic [15:0] data, input int exp_lat, input string tag);
    ld_mar = 1'b1; ld_mar_spc = 1'b1; mar_spc_in = addr;
    ld_mdr = 1'b1; sel_mdr = 2'b11; mdr_spc_in = data; mem_we = 1'b1;
    model_wr(addr, data);
    run_access(1'b0, exp_lat, 1'b0, tag);
    ld_mar_spc = 1'b0;
  endtask

  initial begin
    dsel = 1'b0;
    bus_in = 16'h0; mar_spc_in = 16'h0; mdr_spc_in = 16'h0;
    idle_ctrl();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_mar", mar_s, 16'h0);
    chk("rst_mdr", mdr_s, 16'h0);
    chk("rst_rdy", rdy_s, 0);
    chk("rst_bus", bus_out_s, 16'h0);

    write_spc(16'h3004, 16'h1111, 2, "init4");

    write_spc(16'h3001, 16'hE207, 2, "prewr");
    chk("prewr_mar", mar_s, 16'h3001);
    read_at(16'h3001, 2, 1'b0, "rdback");
    ena_mdr = 1'b1; #1;
    chk("bus_on", bus_out_s, 16'hE207);
    chk("drv_on", drv_s, 1);
    ena_mdr = 1'b0; #1;
    chk("bus_off", bus_out_s, 16'h0);
    chk("drv_off", drv_s, 0);

    ld_mdr = 1'b1; sel_mdr = 2'b10; bus_in = 16'hAAAA;
    step(); step();
    chk("sel10_mdr", mdr_s, 16'hE207);
    chk("sel10_rdy", rdy_s, 0);
    ld_mdr = 1'b0; sel_mdr = 2'b00;

    read_at(16'h3001, 2, 1'b1, "lock");
    chk("lock_mar", mar_s, 16'h3001);
    read_at(16'h3004, 2, 1'b0, "lock_ram");

    ld_mar = 1'b1; ld_mar_spc = 1'b0; bus_in = 16'h3003;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b1; sel_mdr = 2'b00; bus_in = 16'h1843;
    step();
    sel_mdr = 2'b01; mem_we = 1'b1;
    model_wr(16'h3003, 16'h1843);
    run_access(1'b0, 2, 1'b0, "prio");
    chk("prio_mdr", mdr_s, 16'h1843);
    read_at(16'h3003, 2, 1'b0, "prio_rd");

    ld_mar = 1'b1; ld_mar_spc = 1'b1; mar_spc_in = 16'h3004;
    ld_mdr = 1'b1; sel_mdr = 2'b11; mdr_spc_in = 16'h1A6F; mem_we = 1'b1;
    step();
    idle_ctrl();
    mem_we = 1'b1;
    step();
    reset = 1'b1; mem_we = 1'b0;
    step();
    reset = 1'b0;
    chk("rstw_mar", mar_s, 16'h0);
    chk("rstw_mdr", mdr_s, 16'h0);
    chk("rstw_rdy", rdy_s, 0);
    read_at(16'h3004, 2, 1'b0, "rstw_rd");

    dsel = 1'b1;
    idle_ctrl();
    write_spc(16'hFF05, 16'hBEEF, 4, "alias_wr");
    read_at(16'h0005, 4, 1'b0, "alias_rd");

    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_unit.md
Name: lc3_mem_unit

Overview:
- Memory-side responder for the LC-3 control FSM.
- Owns MAR, MDR and a parameterised word-addressed RAM, and executes the control unit's ldMAR/ldMDR/selMDR/memWE commands.
- Reports completion of each multi-cycle memory access on a ready (R) handshake, which the control FSM polls before leaving its fetch/load/store states.
- Drives the shared 16-bit bus from MDR when enaMDR is high.

Parameters:
ADDR_W, 8, RAM address bits; RAM holds 2^ADDR_W 16-bit words; MAR[ADDR_W-1:0] indexes it.
MEM_LAT, 2, cycles from request acceptance to data/commit (1..15).

Ports:
clk  in  1  system clock, posedge only
reset  in  1  synchronous, active-high
bus_in  in  16  shared datapath bus value
mar_spc_in  in  16  preload address (MARSpcIn)
mdr_spc_in  in  16  preload data (MDRSpcIn)
ld_mar  in  1  load MAR
ld_mar_spc  in  1  MAR source: 1 = mar_spc_in, 0 = bus_in
ld_mdr  in  1  load MDR / read request
sel_mdr  in  2  MDR source: 00 bus_in, 01 RAM read, 11 mdr_spc_in, 10 reserved (no load)
mem_we  in  1  write request: RAM[MAR] <= MDR
ena_mdr  in  1  bus drive enable
bus_out  out  16  MDR value when ena_mdr = 1, else 16'h0000
bus_drive  out  1  equals ena_mdr (tri-state enable for top level)
mem_ready  out  1  R: access complete
mar_q  out  16  current MAR (debug)
mdr_q  out  16  current MDR (debug)

Behaviour:
- Reset (sync, active-high):
  - MAR = 0, MDR = 0, FSM = IDLE, latency counter = 0, mem_ready = 0.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access: no RAM write is committed and MDR is not updated.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE (2-bit encoding).
- IDLE:
  - ld_mar: MAR <= (ld_mar_spc ? mar_spc_in : bus_in) on the next edge.
  - ld_mdr with sel_mdr 00/11: MDR <= bus_in / mdr_spc_in on the next edge. Single cycle, no FSM change, mem_ready stays 0.
  - ld_mdr with sel_mdr 01: accept a read, counter <= MEM_LAT-1, go to RD_WAIT.
  - mem_we: accept a write, go to WR_WAIT.
    - mem_we has priority over a simultaneous read request; the read is ignored.
    - A same-cycle direct MDR load (sel 00/11) together with mem_we also takes effect, and the write uses the newly loaded MDR.
    - A same-cycle ld_mar is also honoured, and the access uses the new MAR.
    - Requirement: the access captures address and data at the end of the accept cycle, not at acceptance.
- RD_WAIT / WR_WAIT:
  - Counter decrements each cycle.
  - At counter = 0, the read loads MDR <= RAM[MAR[ADDR_W-1:0]], or the write commits RAM[MAR] <= MDR. Then go to DONE.
  - Total latency from the accept edge to mem_ready high is MEM_LAT cycles.
  - While busy, ld_mar, ld_mdr and mem_we are ignored; MAR and MDR are frozen.
- DONE:
  - mem_ready = 1 (registered).
  - Stay in DONE while the originating request is still high (ld_mdr&&sel_mdr==01 for a read, mem_we for a write).
  - Return to IDLE, mem_ready = 0, on the first cycle the request is low. This prevents re-issue from level-held controls.
- Addressing: MAR bits above ADDR_W-1 are ignored, so addresses alias. Example with ADDR_W=8: 16'h3001 maps to RAM[8'h01].
- RAM read in RD_WAIT is synchronous, registered into MDR.
- bus_out is combinational from MDR and ena_mdr; it is independent of FSM state.
- sel_mdr = 10 with ld_mdr: MDR holds and no access starts.

Decomposition:
- Shared package lc3_pkg:
  - Memory FSM state enum: MEM_IDLE, MEM_RD_WAIT, MEM_WR_WAIT, MEM_DONE.
  - sel_mdr encodings: SEL_MDR_BUS=2'b00, SEL_MDR_MEM=2'b01, SEL_MDR_SPC=2'b11.
  - LC3_WORD_W=16.
- One sub-module: lc3_sram (single-port, sync read/write, params ADDR_W and data width 16). It is instantiated once; the FSM, MAR/MDR and counter stay in lc3_mem_unit.

Test Plan:
- Preload write:
  - Stimulus: ld_mar=1, ld_mar_spc=1, mar_spc_in=16'h3001, ld_mdr=1, sel_mdr=11, mdr_spc_in=16'hE207, mem_we=1 held.
  - Response: mem_ready rises 2 cycles after the accept edge and stays high while mem_we=1. RAM[1]=16'hE207.
  - After mem_we drops: mem_ready=0 next cycle.
- Read back:
  - Stimulus: bus_in=16'h3001, ld_mar=1, then ld_mdr=1 sel_mdr=01 held.
  - Response: mdr_q=16'hE207 the same cycle mem_ready=1. With ena_mdr=1, bus_out=16'hE207; with ena_mdr=0, bus_out=16'h0000.
- Busy lockout:
  - Stimulus: during RD_WAIT, pulse ld_mar with bus_in=16'h3004 and mem_we=1.
  - Response: mar_q unchanged, RAM unchanged, FSM completes the read only.
- Priority:
  - Stimulus: in IDLE, mem_we=1 and ld_mdr=1 sel_mdr=01 in the same cycle, MDR=16'h1843, MAR=16'h3003.
  - Response: write path taken, RAM[3]=16'h1843, MDR unchanged.
- Reset mid-write:
  - Stimulus: assert reset 1 cycle after a write to 16'h3004 with MDR=16'h1A6F is accepted.
  - Response: RAM[4] keeps its old value; mar_q=0, mdr_q=0, mem_ready=0, FSM=IDLE.
- Aliasing / latency:
  - Stimulus: set MEM_LAT=4, write 16'hBEEF to 16'hFF05, then read from 16'h0005.
  - Response: returns 16'hBEEF, and mem_ready rises exactly 4 cycles after each accept edge.
